// File: rtl/bram_fifo_pkg.sv
// Shared constants and width-dependent geometry for the 18-bit-half BRAM FIFO controller.
// Both the controller and its bus interface size themselves from these lookups.
package bram_fifo_pkg;

   localparam int RAM_ADDR_W = 15;
   localparam int RAM_DATA_W = 18;
   localparam int PARITY_BIT = 16;

   function automatic int fifo_depth(input int data_width);
      return (data_width == 9) ? 2048 : 1024;
   endfunction

   // The RAM address is bit-granular within the 18-bit half, so word index sits above these bits.
   function automatic int addr_lsb(input int data_width);
      return (data_width == 9) ? 3 : 4;
   endfunction

endpackage

// File: rtl/bram_fifo_if.sv
// FIFO controller bus: producer/consumer handshake, status flags and the RAM port signals.
// The slave side is the controller; the master side is the surrounding logic plus the RAM.
interface bram_fifo_if #(
   parameter int DATA_WIDTH = 18
);
   import bram_fifo_pkg::*;

   localparam int PTR_W = $clog2(fifo_depth(DATA_WIDTH));

   logic                  flush;
   logic                  push;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  pop;
   logic [DATA_WIDTH-1:0] pop_data;
   logic                  pop_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [PTR_W:0]        count;
   logic                  overflow;
   logic                  underflow;
   logic [RAM_ADDR_W-1:0] wr_addr;
   logic                  wr_en;
   logic [1:0]            wr_be;
   logic [RAM_DATA_W-1:0] wr_data;
   logic [RAM_ADDR_W-1:0] rd_addr;
   logic                  rd_en;
   logic [RAM_DATA_W-1:0] rd_data;

   modport slave (
      input  flush, push, push_data, pop, rd_data,
      output pop_data, pop_valid, full, empty, almost_full, almost_empty, count,
             overflow, underflow, wr_addr, wr_en, wr_be, wr_data, rd_addr, rd_en
   );

   modport master (
      output flush, push, push_data, pop, rd_data,
      input  pop_data, pop_valid, full, empty, almost_full, almost_empty, count,
             overflow, underflow, wr_addr, wr_en, wr_be, wr_data, rd_addr, rd_en
   );

endinterface

// File: rtl/bram_fifo_ptr.sv
// Wrapping FIFO pointer with increment enable and synchronous clear.
// DEPTH is a power of two, so natural binary rollover gives the DEPTH-1 -> 0 wrap.
module bram_fifo_ptr #(
   parameter int PTR_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (clr)
         ptr <= '0;
      else if (inc)
         ptr <= ptr + PTR_W'(1);
   end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Single-clock FIFO controller driving one 18-bit half of an RS_TDP36K in simple-dual-port mode.
// Owns pointers, occupancy and flags; applies 9-bit parity packing on both RAM ports.
module bram_fifo_ctrl
   import bram_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 18,
   parameter int AFULL_THRESH  = fifo_depth(DATA_WIDTH) - 4,
   parameter int AEMPTY_THRESH = 4
) (
   input logic        clk,
   input logic        rst,
   bram_fifo_if.slave bus
);

   localparam int DEPTH    = fifo_depth(DATA_WIDTH);
   localparam int PTR_W    = $clog2(DEPTH);
   localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] AF_CNT   = (PTR_W+1)'(AFULL_THRESH);
   localparam logic [PTR_W:0] AE_CNT   = (PTR_W+1)'(AEMPTY_THRESH);

   if (DATA_WIDTH != 9 && DATA_WIDTH != 18) begin : g_bad_width
      $error("bram_fifo_ctrl: DATA_WIDTH must be 9 or 18");
   end

   logic [PTR_W-1:0]      wptr;
   logic [PTR_W-1:0]      rptr;
   logic                  push_ok;
   logic                  pop_ok;
   logic [PTR_W:0]        count_nxt;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] pop_data_q;

   // Registered flags gate acceptance: a same-cycle pop never frees room for a push, and vice versa.
   assign push_ok = bus.push & ~bus.full  & ~bus.flush;
   assign pop_ok  = bus.pop  & ~bus.empty & ~bus.flush;

   assign bus.wr_en   = push_ok;
   assign bus.wr_be   = {2{push_ok}};
   assign bus.rd_en   = pop_ok;
   assign bus.wr_addr = RAM_ADDR_W'({wptr, {ADDR_LSB{1'b0}}});
   assign bus.rd_addr = RAM_ADDR_W'({rptr, {ADDR_LSB{1'b0}}});

   bram_fifo_ptr #(.PTR_W(PTR_W)) u_wptr (
      .clk (clk),
      .rst (rst),
      .clr (bus.flush),
      .inc (push_ok),
      .ptr (wptr)
   );

   bram_fifo_ptr #(.PTR_W(PTR_W)) u_rptr (
      .clk (clk),
      .rst (rst),
      .clr (bus.flush),
      .inc (pop_ok),
      .ptr (rptr)
   );

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      count_nxt = bus.count;
      if (bus.flush)
         count_nxt = '0;
      else if (push_ok && !pop_ok)
         count_nxt = bus.count + (PTR_W+1)'(1);
      else if (pop_ok && !push_ok)
         count_nxt = bus.count - (PTR_W+1)'(1);
   end

   if (DATA_WIDTH == 9) begin : g_w9
      logic unused_rd_bits;

      always_comb begin
         bus.wr_data             = '0;
         bus.wr_data[PARITY_BIT] = bus.push_data[8];
         bus.wr_data[7:0]        = bus.push_data[7:0];
      end

      assign rd_word        = {bus.rd_data[PARITY_BIT], bus.rd_data[7:0]};
      assign unused_rd_bits = ^{bus.rd_data[17], bus.rd_data[15:8]};
   end else begin : g_w18
      assign bus.wr_data = bus.push_data;
      assign rd_word     = bus.rd_data;
   end

   // RAM output is valid only in the pop_valid cycle; the hold register keeps it visible afterwards.
   assign bus.pop_data = bus.pop_valid ? rd_word : pop_data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.count        <= '0;
         bus.full         <= 1'b0;
         bus.empty        <= 1'b1;
         bus.almost_full  <= 1'b0;
         bus.almost_empty <= 1'b1;
         bus.overflow     <= 1'b0;
         bus.underflow    <= 1'b0;
         bus.pop_valid    <= 1'b0;
         pop_data_q       <= '0;
      end else begin
         bus.count        <= count_nxt;
         bus.full         <= (count_nxt == FULL_CNT);
         bus.empty        <= (count_nxt == '0);
         bus.almost_full  <= (count_nxt >= AF_CNT);
         bus.almost_empty <= (count_nxt <= AE_CNT);
         bus.pop_valid    <= pop_ok;
         if (bus.pop_valid)
            pop_data_q <= rd_word;
         if (bus.flush) begin
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
         end else begin
            if (bus.push && bus.full)
               bus.overflow <= 1'b1;
            if (bus.pop && bus.empty)
               bus.underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl at widths 18 and 9, each backed by a simple synchronous RAM model.
// Inputs change 1 ns after the rising edge; outputs are sampled 1-2 ns after it.
module tb_bram_fifo_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec  = 0;
   int   nmiss = 0;

   always #5 clk = ~clk;

   bram_fifo_if #(.DATA_WIDTH(18)) a ();
   bram_fifo_if #(.DATA_WIDTH(9))  b ();

   bram_fifo_ctrl #(.DATA_WIDTH(18)) dut18 (.clk(clk), .rst(rst), .bus(a.slave));
   bram_fifo_ctrl #(.DATA_WIDTH(9))  dut9  (.clk(clk), .rst(rst), .bus(b.slave));

   logic [17:0] mem_a [1024];
   logic [17:0] mem_b [2048];

   always @(posedge clk) begin
      if (a.wr_en) mem_a[a.wr_addr[13:4]] <= a.wr_data;
      if (a.rd_en) a.rd_data <= mem_a[a.rd_addr[13:4]];
      if (b.wr_en) mem_b[b.wr_addr[13:3]] <= b.wr_data;
      if (b.rd_en) b.rd_data <= mem_b[b.rd_addr[13:3]];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmiss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic push, input logic [17:0] d, input logic pop, input logic flush);
      a.push = push; a.push_data = d; a.pop = pop; a.flush = flush;
      #1;
   endtask

   task automatic drive_b(input logic push, input logic [8:0] d, input logic pop, input logic flush);
      b.push = push; b.push_data = d; b.pop = pop; b.flush = flush;
      #1;
   endtask

   function automatic logic [17:0] wdat(input int k);
      return 18'((k * 37) ^ 32'h2A5A5);
   endfunction

   int errs;

   initial begin
      a.push = 0; a.push_data = '0; a.pop = 0; a.flush = 0;
      b.push = 0; b.push_data = '0; b.pop = 0; b.flush = 0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      check("rst_count", a.count, 0);
      check("rst_empty", a.empty, 1);
      check("rst_aempty", a.almost_empty, 1);
      check("rst_full", a.full, 0);
      check("rst_afull", a.almost_full, 0);
      check("rst_pop_valid", a.pop_valid, 0);
      check("rst_pop_data", a.pop_data, 0);
      check("rst_ovf_unf", {a.overflow, a.underflow}, 0);
      check("rst_wr_rd_en", {a.wr_en, a.rd_en}, 0);
      check("rst_b_empty", b.empty, 1);
      rst = 1'b0;

      // Two pushes then two pops at width 18
      drive_a(1, 18'h3FFFF, 0, 0);
      check("t1_wr_en", a.wr_en, 1);
      check("t1_wr_be", a.wr_be, 2'b11);
      check("t1_wr_addr0", a.wr_addr, 15'h0000);
      check("t1_wr_data0", a.wr_data, 18'h3FFFF);
      tick();
      check("t1_empty_drop", a.empty, 0);
      check("t1_count1", a.count, 1);
      drive_a(1, 18'h00001, 0, 0);
      check("t1_wr_addr1", a.wr_addr, 15'h0010);
      tick();
      drive_a(0, '0, 1, 0);
      check("t1_rd_en", a.rd_en, 1);
      check("t1_rd_addr0", a.rd_addr, 15'h0000);
      tick();
      check("t1_pop_valid0", a.pop_valid, 1);
      check("t1_pop_data0", a.pop_data, 18'h3FFFF);
      drive_a(0, '0, 1, 0);
      check("t1_rd_addr1", a.rd_addr, 15'h0010);
      tick();
      check("t1_pop_valid1", a.pop_valid, 1);
      check("t1_pop_data1", a.pop_data, 18'h00001);
      check("t1_empty_back", a.empty, 1);
      drive_a(0, '0, 0, 0);
      tick();
      check("t1_pop_valid_idle", a.pop_valid, 0);
      check("t1_pop_data_hold", a.pop_data, 18'h00001);

      // Pop while empty, then flush clears underflow
      drive_a(0, '0, 1, 0);
      check("t2_rd_en_empty", a.rd_en, 0);
      tick();
      check("t2_pop_valid", a.pop_valid, 0);
      check("t2_underflow", a.underflow, 1);
      drive_a(0, '0, 0, 1);
      tick();
      check("t2_underflow_clr", a.underflow, 0);
      check("t2_empty", a.empty, 1);

      // Fill to 1024, threshold boundaries, overflow, push+pop while full
      for (int i = 0; i < 1024; i++) begin
         drive_a(1, wdat(i), 0, 0);
         tick();
         if (i == 3)    check("t3_aempty_at4", a.almost_empty, 1);
         if (i == 4)    check("t3_aempty_at5", a.almost_empty, 0);
         if (i == 1018) check("t3_afull_at1019", a.almost_full, 0);
         if (i == 1019) check("t3_afull_at1020", a.almost_full, 1);
      end
      check("t3_full", a.full, 1);
      check("t3_count_full", a.count, 1024);
      drive_a(1, 18'h12345, 0, 0);
      check("t3_wr_en_full", a.wr_en, 0);
      tick();
      check("t3_overflow", a.overflow, 1);
      check("t3_count_still", a.count, 1024);
      drive_a(1, 18'h2AAAA, 1, 0);
      check("t3_pp_wr_en", a.wr_en, 0);
      check("t3_pp_rd_en", a.rd_en, 1);
      tick();
      check("t3_pp_count", a.count, 1023);
      check("t3_pp_full", a.full, 0);
      check("t3_pp_pop_data", a.pop_data, wdat(0));
      drive_a(0, '0, 0, 1);
      tick();
      check("t3_flush_count", a.count, 0);
      check("t3_flush_empty", a.empty, 1);
      check("t3_flush_ovf", a.overflow, 0);

      // Streaming push/pop across the pointer wrap
      errs = 0;
      for (int k = 0; k <= 1030; k++) begin
         drive_a(1, wdat(k), (k > 0), 0);
         if (k == 1024) check("t4_rd_addr_top", a.rd_addr, 15'h3FF0);
         if (k == 1024) check("t4_wr_addr_wrap", a.wr_addr, 15'h0000);
         if (k == 1025) check("t4_rd_addr_wrap", a.rd_addr, 15'h0000);
         tick();
         if (k > 0 && (a.pop_valid !== 1'b1 || a.pop_data !== wdat(k - 1))) errs++;
      end
      check("t4_stream_errors", errs, 0);
      check("t4_count_steady", a.count, 1);
      drive_a(0, '0, 1, 0);
      tick();
      check("t4_last_word", a.pop_data, wdat(1030));
      check("t4_empty", a.empty, 1);

      // Reset mid-operation with COUNT = 5 and a read in flight
      for (int i = 0; i < 5; i++) begin
         drive_a(1, 18'(100 + i), 0, 0);
         tick();
      end
      drive_a(1, 18'h00200, 1, 0);
      tick();
      check("t5_count5", a.count, 5);
      check("t5_pop_valid_pre", a.pop_valid, 1);
      drive_a(0, '0, 0, 0);
      rst = 1'b1;
      #1;
      check("t5_rst_count", a.count, 0);
      check("t5_rst_empty", a.empty, 1);
      check("t5_rst_aempty", a.almost_empty, 1);
      check("t5_rst_pop_valid", a.pop_valid, 0);
      check("t5_rst_pop_data", a.pop_data, 0);
      check("t5_rst_flags", {a.full, a.almost_full, a.overflow, a.underflow}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive_a(1, 18'h0BEEF, 0, 0);
      check("t5_wr_addr_after", a.wr_addr, 15'h0000);
      check("t5_wr_en_after", a.wr_en, 1);
      tick();
      check("t5_count_after", a.count, 1);
      drive_a(0, '0, 0, 0);

      // Width 9 parity packing and unpacking
      drive_b(1, 9'h1A5, 0, 0);
      check("t6_wr_data0", b.wr_data, 18'h100A5);
      check("t6_wr_addr0", b.wr_addr, 15'h0000);
      tick();
      drive_b(1, 9'h05A, 0, 0);
      check("t6_wr_data1", b.wr_data, 18'h0005A);
      check("t6_wr_addr1", b.wr_addr, 15'h0008);
      tick();
      drive_b(0, '0, 1, 0);
      check("t6_rd_addr0", b.rd_addr, 15'h0000);
      tick();
      check("t6_pop_valid", b.pop_valid, 1);
      check("t6_pop_data0", b.pop_data, 9'h1A5);
      drive_b(0, '0, 1, 0);
      check("t6_rd_addr1", b.rd_addr, 15'h0008);
      tick();
      check("t6_pop_data1", b.pop_data, 9'h05A);
      check("t6_empty", b.empty, 1);
      drive_b(0, '0, 0, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
      $finish;
   end

endmodule

// File: doc/bram_fifo_ctrl.md
# bram_fifo_ctrl

Single-clock synchronous FIFO controller that sits directly upstream of one 18-bit half of an RS_TDP36K block RAM. It owns the write and read pointers, occupancy count and status flags. It drives the RAM's write port (port B1) and read port (port A1) in simple-dual-port fashion: address, enable, byte-enable and data. It returns registered read data to the consumer, applying the 9-bit parity packing itself.

## Interface
- DATA_WIDTH, 18: FIFO word width; legal values 9 or 18 only, anything else is an elaboration error.
- AFULL_THRESH, DEPTH-4: ALMOST_FULL asserts when COUNT >= this value.
- AEMPTY_THRESH, 4: ALMOST_EMPTY asserts when COUNT <= this value.
- Derived localparams:
  - DEPTH = 1024 for width 18, 2048 for width 9.
  - PTR_W = log2(DEPTH).
  - ADDR_LSB = 4 for width 18, 3 for width 9.
- CLK  in  1  sole clock; RAM write and read clocks are tied to it externally.
- RST  in  1  asynchronous, active-high reset.
- FLUSH  in  1  synchronous clear of pointers, count and sticky flags.
- PUSH  in  1  write request.
- PUSH_DATA  in  DATA_WIDTH  write word.
- POP  in  1  read request.
- POP_DATA  out  DATA_WIDTH  read word; valid only while POP_VALID is high.
- POP_VALID  out  1  one-cycle pulse marking POP_DATA.
- FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY  out  1 each  registered status flags.
- COUNT  out  PTR_W+1  current occupancy.
- OVERFLOW, UNDERFLOW  out  1 each  sticky error flags; cleared by RST or FLUSH.
- WR_ADDR  out  15  RAM write address.
- WR_EN  out  1  RAM write enable.
- WR_BE  out  2  RAM write byte enables.
- WR_DATA  out  18  RAM write data.
- RD_ADDR  out  15  RAM read address.
- RD_EN  out  1  RAM read enable.
- RD_DATA  in  18  RAM read data, valid one cycle after RD_EN.

## Operation
- Acceptance:
  - push_ok = PUSH & !FULL.
  - pop_ok = POP & !EMPTY.
  - Both use the registered flags. A pop in the same cycle does not free a slot for a push while FULL, and a push does not make data available to a pop while EMPTY.
- Write side (combinational from the accepting cycle):
  - WR_EN = push_ok.
  - WR_BE = 2'b11 when push_ok, else 2'b00.
  - WR_ADDR = {wptr, ADDR_LSB zeros}, zero-extended to 15 bits.
- Read side (combinational): RD_EN = pop_ok; RD_ADDR formed from rptr the same way.
- Write data packing:
  - Width 18: WR_DATA = PUSH_DATA.
  - Width 9: WR_DATA bit 16 = PUSH_DATA[8], bits 7:0 = PUSH_DATA[7:0], all other bits 0.
- Read data unpacking:
  - Width 18: POP_DATA = RD_DATA.
  - Width 9: POP_DATA = {RD_DATA[16], RD_DATA[7:0]}.
- Pointers: wptr advances on push_ok, rptr advances on pop_ok. Both wrap from DEPTH-1 to 0.
- COUNT update: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither occur.
- Flags, all derived from the next-state COUNT:
  - FULL = (COUNT == DEPTH).
  - EMPTY = (COUNT == 0).
  - ALMOST_FULL and ALMOST_EMPTY compare against their thresholds.
- Error flags:
  - OVERFLOW sets on PUSH & FULL.
  - UNDERFLOW sets on POP & EMPTY.
  - A rejected request has no other effect.
- FLUSH:
  - Zeroes both pointers and COUNT, sets EMPTY, clears the sticky flags.
  - Suppresses push_ok and pop_ok in that cycle.
  - A POP_VALID already in flight from the previous cycle still fires.
- Read-during-write collision cannot occur: reads only target occupied entries, writes only target free ones.

## Timing
- Reset values:
  - POP_VALID, FULL, ALMOST_FULL, OVERFLOW, UNDERFLOW = 0.
  - EMPTY = 1.
  - ALMOST_EMPTY = 1.
  - COUNT = 0; pointers = 0; POP_DATA = 0.
  - WR_EN and RD_EN are 0, because the flags force acceptance low.
- Read latency: pop_ok in cycle N; POP_VALID high and POP_DATA valid in cycle N+1. POP_DATA holds its value until the next valid read.
- Write-to-read latency: a word pushed in cycle N is counted in cycle N+1, so EMPTY drops in N+1 and the earliest accepted pop is in N+1.
- Flags and COUNT update on the clock edge that ends the accepting cycle.
- Asserting RST mid-operation clears everything immediately. RAM contents are undefined from the FIFO's view afterwards.
- Sustained throughput is one push and one pop per cycle.

## Structure
- Shared package bram_fifo_pkg holds:
  - the DEPTH and ADDR_LSB lookup functions indexed by DATA_WIDTH;
  - the 15-bit RAM address width constant;
  - the 9-bit parity bit position (16).
- One sub-module, bram_fifo_ptr: a wrapping pointer with increment enable and synchronous clear, instantiated once for write and once for read.
- The RS_TDP36K instance is not inside this block; it is connected at the parent level.

## Test plan
- Width 18, push 0x3FFFF then 0x00001, then pop twice:
  - WR_ADDR = 0x0000, then 0x0010;
  - POP_DATA = 0x3FFFF, then 0x00001, each one cycle after its pop;
  - EMPTY returns to 1.
- Width 18, 1024 pushes with no pops:
  - FULL = 1 and COUNT = 1024;
  - a 1025th push leaves WR_EN = 0 and sets OVERFLOW;
  - a simultaneous push+pop while FULL gives COUNT = 1023.
- Width 9, push 0x1A5:
  - WR_DATA = 0x100A5 (bit 16 set, low byte 0xA5);
  - with RD_DATA = 0x100A5, the next pop gives POP_DATA = 0x1A5.
- Wrap-around: after 1020 push/pop pairs, continue 10 more pairs; RD_ADDR wraps from 0x3FF0 to 0x0000 with no data loss.
- Pop while EMPTY: RD_EN = 0, POP_VALID stays 0, UNDERFLOW = 1; a following FLUSH clears UNDERFLOW.
- Reset mid-operation: assert RST with COUNT = 5; all outputs return to the reset values immediately, and the next push lands at WR_ADDR 0.
